// File: rtl/jtgng_joy_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the serial joystick transmitter: FSM states, default
// frame length and the table that maps each serial position to a button.
package jtgng_joy_pkg;

  localparam int FRAME_LEN_DEF = 25;
  localparam int MAP_LEN       = 24;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } joy_state_e;

  // player: 0 = joystick1, 1 = joystick2; bit_idx selects the button bit.
  typedef struct packed {
    logic       player;
    logic [3:0] bit_idx;
  } map_entry_t;

  // Entry [i] describes serial position i+1 (listed here from position 24 down).
  localparam map_entry_t [MAP_LEN-1:0] POS_MAP = {
    {1'b0, 4'd7},  {1'b0, 4'd9},  {1'b0, 4'd11}, {1'b0, 4'd10},
    {1'b1, 4'd7},  {1'b1, 4'd9},  {1'b1, 4'd11}, {1'b1, 4'd10},
    {1'b1, 4'd3},  {1'b1, 4'd2},  {1'b1, 4'd1},  {1'b1, 4'd0},
    {1'b1, 4'd4},  {1'b1, 4'd5},  {1'b1, 4'd6},  {1'b1, 4'd8},
    {1'b0, 4'd3},  {1'b0, 4'd2},  {1'b0, 4'd1},  {1'b0, 4'd0},
    {1'b0, 4'd4},  {1'b0, 4'd5},  {1'b0, 4'd6},  {1'b0, 4'd8}
  };

  // Returns the active-high pressed state in serial order (bit i = position i+1).
  function automatic logic [MAP_LEN-1:0] map_buttons(input logic [15:0] j1,
                                                     input logic [15:0] j2);
    logic [MAP_LEN-1:0] pressed;
    pressed = '0;
    for (int i = 0; i < MAP_LEN; i++) begin
      pressed[i] = POS_MAP[i].player ? j2[POS_MAP[i].bit_idx] : j1[POS_MAP[i].bit_idx];
    end
    return pressed;
  endfunction

endpackage

// File: rtl/jtgng_sync_bit.sv
`timescale 1ns/1ps
// Multi-flop synchronizer bringing one asynchronous bit into the clk_sys domain.
module jtgng_sync_bit #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], din};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbour and the chain really shifts.
  always_ff @(posedge clk_sys) begin
    if (rst) chain_q <= {STAGES{RST_VAL}};
    else     chain_q <= chain_d;
  end

  assign dout = chain_q[STAGES-1];

endmodule

// File: rtl/jtgng_joy_ser_tx.sv
`timescale 1ns/1ps
// Serial joystick transmitter: snapshots two 16-bit button words on a load
// strobe and shifts them out, active-low, one position per reader clock edge.
module jtgng_joy_ser_tx
  import jtgng_joy_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_LEN   = FRAME_LEN_DEF
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic [15:0] joystick1,
  input  logic [15:0] joystick2,
  input  logic        joy_clk,
  input  logic        joy_load,
  output logic        joy_data,
  output logic        busy,
  output logic        frame_done
);

  localparam int POS_W  = $clog2(FRAME_LEN + 1);
  localparam int LOAD_N = (FRAME_LEN - 1 < MAP_LEN) ? FRAME_LEN - 1 : MAP_LEN;

  logic joy_clk_s, joy_load_s, clk_rise;

  jtgng_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
    .clk_sys (clk_sys),
    .rst     (rst),
    .din     (joy_clk),
    .dout    (joy_clk_s)
  );

  jtgng_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_load (
    .clk_sys (clk_sys),
    .rst     (rst),
    .din     (joy_load),
    .dout    (joy_load_s)
  );

  joy_state_e           state_q, state_d;
  logic [POS_W-1:0]     pos_q, pos_d;
  logic [FRAME_LEN-1:0] sr_q, sr_d;
  logic                 joy_clk_prev_q, joy_clk_prev_d;
  logic                 joy_data_q, joy_data_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;

  logic [MAP_LEN-1:0]   pressed;
  logic [FRAME_LEN-1:0] load_frame;
  logic                 unused_btn;

  assign clk_rise   = joy_clk_s & ~joy_clk_prev_q;
  assign unused_btn = ^{joystick1[15:12], joystick2[15:12]};

  // Frame image kept active-low; position 0 is the idle-high pad bit.
  always_comb begin
    pressed    = map_buttons(joystick1, joystick2);
    load_frame = '1;
    for (int p = 0; p < LOAD_N; p++) begin
      load_frame[p+1] = ~pressed[p];
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    pos_d          = pos_q;
    sr_d           = sr_q;
    frame_done_d   = 1'b0;
    joy_clk_prev_d = joy_clk_s;

    unique case (state_q)
      ST_IDLE:  if (!joy_load_s) state_d = ST_LOAD;
      ST_LOAD:  if (joy_load_s)  state_d = ST_SHIFT;
      ST_SHIFT: begin
        // A load request wins over a simultaneous clock edge.
        if (!joy_load_s) begin
          state_d = ST_LOAD;
        end else if (clk_rise) begin
          sr_d  = {1'b1, sr_q[FRAME_LEN-1:1]};
          pos_d = pos_q + POS_W'(1);
          if (pos_d == POS_W'(FRAME_LEN)) begin
            state_d      = ST_DONE;
            frame_done_d = 1'b1;
          end
        end
      end
      ST_DONE:  if (!joy_load_s) state_d = ST_LOAD;
      default:  state_d = ST_IDLE;
    endcase

    if (state_d == ST_LOAD) begin
      sr_d  = load_frame;
      pos_d = '0;
    end

    joy_data_d = (state_d == ST_SHIFT) ? sr_d[0] : 1'b1;
    busy_d     = (state_d == ST_LOAD) || (state_d == ST_SHIFT);
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      pos_q          <= '0;
      sr_q           <= '1;
      joy_clk_prev_q <= 1'b0;
      joy_data_q     <= 1'b1;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      pos_q          <= pos_d;
      sr_q           <= sr_d;
      joy_clk_prev_q <= joy_clk_prev_d;
      joy_data_q     <= joy_data_d;
      busy_q         <= busy_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign joy_data   = joy_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_jtgng_joy_ser_tx.sv
`timescale 1ns/1ps
// Scoreboard bench for the serial joystick transmitter: the stimulus pushes the
// expected serial bit for every position, a monitor pops and compares.
module tb_jtgng_joy_ser_tx;

  localparam int FRAME_LEN = 25;
  localparam int PH        = 8;   // joy_clk phase length in clk_sys cycles

  logic        clk_sys = 1'b0;
  logic        rst;
  logic [15:0] joystick1, joystick2;
  logic        joy_clk, joy_load;
  logic        joy_data, busy, frame_done;

  jtgng_joy_ser_tx #(.SYNC_STAGES(2), .FRAME_LEN(FRAME_LEN)) dut (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .joy_clk    (joy_clk),
    .joy_load   (joy_load),
    .joy_data   (joy_data),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk_sys = ~clk_sys;

  // Reader's view of the frame: which player/bit each position 1..24 carries.
  int unsigned map_bit[24] = '{8, 6, 5, 4, 0, 1, 2, 3,
                               8, 6, 5, 4, 0, 1, 2, 3,
                               10, 11, 9, 7, 10, 11, 9, 7};
  bit          map_pl[24]  = '{0, 0, 0, 0, 0, 0, 0, 0,
                               1, 1, 1, 1, 1, 1, 1, 1,
                               1, 1, 1, 1, 0, 0, 0, 0};

  function automatic logic model_bit(input logic [15:0] j1, input logic [15:0] j2,
                                     input int pos);
    logic [15:0] w;
    if (pos < 1 || pos > 24) return 1'b1;
    w = map_pl[pos-1] ? j2 : j1;
    return ~w[map_bit[pos-1]];
  endfunction

  typedef struct {
    string tag;
    int    pos;
    logic  data;
    logic  busy;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;
  logic probe = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares the DUT outputs against the oldest expectation.
  always @(posedge probe) begin
    exp_t e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_underflow: probe with no expectation queued");
    end else begin
      e = exp_q.pop_front();
      check($sformatf("%s_pos%0d_data", e.tag, e.pos), {31'd0, joy_data}, {31'd0, e.data});
      check($sformatf("%s_pos%0d_busy", e.tag, e.pos), {31'd0, busy},     {31'd0, e.busy});
    end
  end

  // frame_done cycles, sampled away from the active edge.
  always @(negedge clk_sys) if (frame_done === 1'b1) done_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic sample(input string tag, input int pos, input logic d, input logic b);
    exp_t e;
    e.tag = tag; e.pos = pos; e.data = d; e.busy = b;
    exp_q.push_back(e);
    probe = 1'b1;
    #1 probe = 1'b0;
  endtask

  task automatic shift_edge(input string tag, input int pos, input logic d, input logic b);
    joy_clk = 1'b1;
    cyc(PH);
    sample(tag, pos, d, b);
    joy_clk = 1'b0;
    cyc(PH);
  endtask

  // Load strobe with a joy_clk edge inside it, which must be ignored.
  task automatic load_pulse(input string tag);
    joy_load = 1'b0;
    cyc(4);
    joy_clk = 1'b1;
    cyc(3);
    sample({tag, "_load"}, 0, 1'b1, 1'b1);
    cyc(3);
    joy_clk = 1'b0;
    cyc(4);
    joy_load = 1'b1;
    cyc(8);
  endtask

  // Everything after load release: pad, 24 button bits, final edge, ignored edges.
  task automatic frame_body(input string tag, input logic [15:0] j1, input logic [15:0] j2);
    int d0;
    d0 = done_cnt;
    sample(tag, 0, 1'b1, 1'b1);
    for (int p = 1; p < FRAME_LEN; p++) shift_edge(tag, p, model_bit(j1, j2, p), 1'b1);
    shift_edge(tag, FRAME_LEN, 1'b1, 1'b0);
    check({tag, "_frame_done_once"}, done_cnt - d0, 1);
    shift_edge({tag, "_done_ign"}, FRAME_LEN, 1'b1, 1'b0);
    shift_edge({tag, "_done_ign"}, FRAME_LEN, 1'b1, 1'b0);
    check({tag, "_done_no_repeat"}, done_cnt - d0, 1);
  endtask

  task automatic run_frame(input string tag, input logic [15:0] j1, input logic [15:0] j2,
                           input logic [15:0] j1_after, input logic [15:0] j2_after);
    joystick1 = j1;
    joystick2 = j2;
    cyc(2);
    load_pulse(tag);
    joystick1 = j1_after;
    joystick2 = j2_after;
    frame_body(tag, j1, j2);
  endtask

  initial begin
    logic [15:0] a1, a2, b1, b2;
    int d0;

    rst = 1'b1; joy_load = 1'b1; joy_clk = 1'b0;
    joystick1 = '0; joystick2 = '0;
    cyc(5);
    sample("reset", 0, 1'b1, 1'b0);
    check("reset_frame_done", {31'd0, frame_done}, 32'd0);
    rst = 1'b0;
    cyc(3);
    shift_edge("idle_ign", 0, 1'b1, 1'b0);
    shift_edge("idle_ign", 0, 1'b1, 1'b0);
    check("idle_no_done", done_cnt, 0);

    run_frame("start_fire", 16'h0110, 16'h0000, 16'h0110, 16'h0000);
    run_frame("coin",       16'h0000, 16'h0200, 16'h0000, 16'h0200);
    run_frame("snap_old",   16'h0110, 16'h0000, 16'h0001, 16'h0000);
    run_frame("snap_new",   16'h0001, 16'h0000, 16'h0001, 16'h0000);

    // Abort after 10 positions, then a fresh frame with new data.
    a1 = 16'($urandom); a2 = 16'($urandom);
    b1 = 16'($urandom); b2 = 16'($urandom);
    joystick1 = a1; joystick2 = a2;
    cyc(2);
    load_pulse("abort_a");
    sample("abort_a", 0, 1'b1, 1'b1);
    for (int p = 1; p <= 10; p++) shift_edge("abort_a", p, model_bit(a1, a2, p), 1'b1);
    d0 = done_cnt;
    joystick1 = b1; joystick2 = b2;
    load_pulse("abort_b");
    check("abort_no_done", done_cnt - d0, 0);
    frame_body("abort_b", b1, b2);

    // Reset in the middle of a frame.
    a1 = 16'($urandom); a2 = 16'($urandom);
    joystick1 = a1; joystick2 = a2;
    cyc(2);
    load_pulse("rst_mid");
    sample("rst_mid", 0, 1'b1, 1'b1);
    for (int p = 1; p <= 12; p++) shift_edge("rst_mid", p, model_bit(a1, a2, p), 1'b1);
    rst = 1'b1;
    cyc(1);
    sample("rst_hit", 12, 1'b1, 1'b0);
    cyc(1);
    rst = 1'b0;
    cyc(2);
    d0 = done_cnt;
    for (int k = 0; k < 30; k++) shift_edge("rst_after", k, 1'b1, 1'b0);
    check("rst_after_no_done", done_cnt - d0, 0);
    run_frame("rst_recover", a1, a2, a1, a2);

    // Load-low and joy_clk rise presented together in SHIFT.
    a1 = 16'($urandom); a2 = 16'($urandom);
    joystick1 = a1; joystick2 = a2;
    cyc(2);
    load_pulse("simul");
    sample("simul", 0, 1'b1, 1'b1);
    for (int p = 1; p <= 5; p++) shift_edge("simul", p, model_bit(a1, a2, p), 1'b1);
    d0 = done_cnt;
    joy_load = 1'b0;
    joy_clk  = 1'b1;
    cyc(6);
    sample("simul_load", 0, 1'b1, 1'b1);
    cyc(2);
    joy_clk = 1'b0;
    cyc(4);
    joy_load = 1'b1;
    cyc(8);
    check("simul_no_done", done_cnt - d0, 0);
    frame_body("simul_restart", a1, a2);

    // Random frames with inputs changing after the snapshot is frozen.
    for (int n = 0; n < 6; n++) begin
      a1 = 16'($urandom); a2 = 16'($urandom);
      b1 = 16'($urandom); b2 = 16'($urandom);
      run_frame($sformatf("rand%0d", n), a1, a2, b1, b2);
    end

    cyc(4);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jtgng_joy_ser_tx.md
JTGNG_JOY_SER_TX -- requirements
Module: jtgng_joy_ser_tx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the synchronizer depth for joy_clk/joy_load (legal 2..4).
REQ-002 SHALL have parameter FRAME_LEN, default 25, the number of bit positions per frame (position 0 pad plus 24 button bits).
REQ-003 clk_sys  input  1  the single system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 joystick1  input  16  player-1 buttons, active-high pressed.
REQ-006 joystick2  input  16  player-2 buttons, active-high pressed.
REQ-007 joy_clk  input  1  serial shift clock from the reader, asynchronous to clk_sys.
REQ-008 joy_load  input  1  parallel-load strobe from the reader, active-low, asynchronous.
REQ-009 joy_data  output  1  serial data to the reader, active-low (0 = pressed).
REQ-010 busy  output  1  high while a frame is loaded or shifting.
REQ-011 frame_done  output  1  one-cycle pulse when the last position has been shifted out.

Function
REQ-012 joy_clk and joy_load SHALL each pass a SYNC_STAGES flop chain; only synchronized copies are used; rising edge of joy_clk detected by one extra flop.
REQ-013 FSM states SHALL be IDLE, LOAD, SHIFT, DONE.
REQ-014 IDLE: joy_data=1, busy=0; synced joy_load low -> LOAD.
REQ-015 LOAD: shift register reloaded every cycle from current inputs, position counter=0, joy_data=1 (pad), busy=1; synced joy_load high -> SHIFT with the last loaded snapshot frozen.
REQ-016 SHIFT: each detected joy_clk rising edge increments position; joy_data shows inverted bit of the current position; position reaching FRAME_LEN -> DONE.
REQ-017 Position map 1..24: j1[8],j1[6],j1[5],j1[4],j1[0],j1[1],j1[2],j1[3], j2[8],j2[6],j2[5],j2[4],j2[0],j2[1],j2[2],j2[3], j2[10],j2[11],j2[9],j2[7], j1[10],j1[11],j1[9],j1[7]; joystick bits 12..15 unused.
REQ-018 DONE: joy_data=1, busy=0, frame_done pulses exactly one cycle on entry; further joy_clk edges ignored; synced joy_load low -> LOAD.
REQ-019 joy_load low in SHIFT SHALL abort: go LOAD, no frame_done.
REQ-020 Simultaneous synced load-low and joy_clk edge SHALL resolve as load; no position increment.
REQ-021 joy_clk edges in IDLE or LOAD SHALL be ignored.
REQ-022 joy_data SHALL update within SYNC_STAGES+2 clk_sys cycles of a joy_clk rising edge; joy_data registered (no combinational path from inputs).
REQ-023 Correct operation SHALL be guaranteed when joy_clk high and low phases each last at least SYNC_STAGES+2 clk_sys cycles.
REQ-024 Input changes during SHIFT SHALL NOT affect the frame in flight.

Reset
REQ-025 While rst=1: state=IDLE, joy_data=1, busy=0, frame_done=0, position=0, shift register all 1s, synchronizer flops 1 (joy_clk chain 0).
REQ-026 rst asserted mid-frame SHALL drop the frame; after release wait for a fresh joy_load low.

Structure
REQ-027 Shared package jtgng_joy_pkg SHALL hold the FSM state enum, FRAME_LEN default, and the position-to-button map table.
REQ-028 Synchronizer SHALL be one sub-module jtgng_sync_bit (parameter STAGES, reset value parameter), instantiated twice.

Verification
REQ-029 j1=16'h0110 (start, fire1): load pulse, 24 clocks -> joy_data 0 at positions 1 and 4, 1 elsewhere; frame_done once.
REQ-030 j2=16'h0200 (coin): full frame -> only position 19 reads 0.
REQ-031 Change j1 to 16'h0001 after load release -> frame still carries previous snapshot; next frame shows position 5 = 0.
REQ-032 Load low after 10 clocks -> no frame_done, busy stays 1, new frame restarts at position 0.
REQ-033 rst pulse at position 12 -> joy_data=1, busy=0 next cycle; 30 joy_clk edges without load -> no frame_done.
REQ-034 Load-low and joy_clk edge in the same synced cycle -> state LOAD, position 0.
